// File: rtl/decode_result_collector.sv
// Re-encodes one-hot decoder words, buffers {error, index} in a FIFO drained over valid/ready,
// and keeps saturating status counters. Optional watchdog: COLLECTOR_TIMEOUT_EN.
module decode_result_collector #(
    parameter int OUTPUT_COUNT   = 16,
    parameter int INDEX_W        = $clog2(OUTPUT_COUNT),
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          pon_rst_i,
    input  logic [OUTPUT_COUNT-1:0]       decoded_output,
    input  logic                          decode_valid,
    input  logic                          clear_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INDEX_W-1:0]            out_index,
    output logic                          out_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          result_count,
    output logic [CNT_WIDTH-1:0]          error_count,
    output logic                          overflow_o,
    output logic                          timeout_o
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [INDEX_W-1:0] enc_index;
    logic               enc_error;
    logic [INDEX_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [INDEX_W:0]   head;
    logic               full;
    logic               pop;
    logic               push;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        enc_index = '0;
        for (int i = OUTPUT_COUNT - 1; i >= 0; i--) begin
            if (decoded_output[i]) enc_index = INDEX_W'(i);
        end
        enc_error = (decoded_output == '0) ||
                    ((decoded_output & (decoded_output - OUTPUT_COUNT'(1))) != '0);
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == PTR_W'(FIFO_DEPTH));
    assign out_valid  = (fifo_level != '0);
    assign pop        = out_valid && out_ready;
    assign push       = decode_valid && (!full || pop);
    assign head       = mem[rd_ptr[ADDR_W-1:0]];
    // Gate the head so outputs read zero while empty, including straight out of reset.
    assign out_index  = out_valid ? head[INDEX_W-1:0] : '0;
    assign out_error  = out_valid ? head[INDEX_W] : 1'b0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= {enc_error, enc_index};
    end

    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            result_count <= '0;
            error_count  <= '0;
            overflow_o   <= 1'b0;
        end else if (clear_i) begin
            result_count <= '0;
            error_count  <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (push && (result_count != '1)) result_count <= result_count + CNT_WIDTH'(1);
            if (push && enc_error && (error_count != '1)) error_count <= error_count + CNT_WIDTH'(1);
            if (decode_valid && !push) overflow_o <= 1'b1;
        end
    end

`ifdef COLLECTOR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (pon_rst_i || clear_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (decode_valid) wd_cnt <= '0;
            else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT_CYCLES)) timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/decode_result_collector.md
Name: decode_result_collector

Overview:
- Downstream stage of the decoder host. Consumes its one-hot decoded_output on each decode_valid pulse.
- Re-encodes the one-hot word to a binary index and checks that it is legal one-hot.
- Buffers {error, index} results in a small synchronous FIFO and drains them over a valid/ready interface.
- Keeps saturating result/error counters and a sticky overflow flag for status readback.

Parameters:
- OUTPUT_COUNT, 16, width of decoded_output; power of 2, minimum 2.
- INDEX_W, $clog2(OUTPUT_COUNT), width of re-encoded index (derived; do not override).
- FIFO_DEPTH, 8, result FIFO entries; power of 2, minimum 2.
- CNT_WIDTH, 16, width of status counters.
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- pon_rst_i  in  1  synchronous active-high reset.
- decoded_output  in  OUTPUT_COUNT  one-hot word from the decoder.
- decode_valid  in  1  qualifies decoded_output; each high cycle is one result.
- clear_i  in  1  sync clear of counters and sticky flags; the FIFO is untouched.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_index  out  INDEX_W  head index.
- out_error  out  1  head was not legal one-hot.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- result_count  out  CNT_WIDTH  results accepted into the FIFO, saturating.
- error_count  out  CNT_WIDTH  accepted results with error=1, saturating.
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full.
- timeout_o  out  1  sticky watchdog flag; tied 0 when the feature is absent.

Behaviour:
- Reset: pon_rst_i sampled high on a clk edge forces:
  - FIFO empty: rd_ptr = wr_ptr = 0, fifo_level = 0, out_valid = 0.
  - out_index = 0, out_error = 0.
  - result_count = 0, error_count = 0, overflow_o = 0, timeout_o = 0.
  - Reset mid-operation discards all buffered entries. Reset has priority over clear_i, push and pop.
- Encode: combinational from decoded_output.
  - index = position of the lowest set bit.
  - error = 1 if the word is zero (index = 0) or has more than one bit set (index = lowest set bit).
- Push occurs when decode_valid = 1.
  - If the FIFO is not full, or a pop happens in the same cycle, write {error, index} at wr_ptr and advance wr_ptr modulo FIFO_DEPTH.
  - Full with no simultaneous pop: drop the entry, set overflow_o, leave the counters unchanged.
- Pop occurs when out_valid && out_ready. It advances rd_ptr modulo FIFO_DEPTH.
- Latency:
  - No bypass path. A push into an empty FIFO shows out_valid = 1 on the cycle after decode_valid.
  - out_index and out_error always reflect the head entry and are stable while out_valid && !out_ready.
- Simultaneous push and pop: fifo_level is unchanged. This is legal at level 0 only if out_valid is already 1, which is impossible at level 0, so at level 0 a push simply raises the level to 1.
- fifo_level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Range 0..FIFO_DEPTH; full is fifo_level == FIFO_DEPTH.
  - Pointers carry an extra wrap bit so that full and empty are distinguishable.
- Counters:
  - result_count increments on each accepted push.
  - error_count increments on each accepted push with error = 1.
  - Both hold at 2^CNT_WIDTH-1.
- clear_i: next cycle, result_count = error_count = 0, overflow_o = 0, timeout_o = 0.
  - clear_i has priority over a same-cycle increment.
  - A push in the same cycle is still stored in the FIFO but is not counted.
- out_ready while out_valid = 0 is ignored.

Optional Feature:
- Macro: COLLECTOR_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYCLES)+1 increments every cycle and resets to 0 on decode_valid.
  - When it reaches TIMEOUT_CYCLES, timeout_o sets and the counter holds.
  - timeout_o is sticky until clear_i or pon_rst_i. clear_i also zeroes the watchdog counter.
- Undefined: no watchdog logic; timeout_o is tied to 0.

Test Plan:
- Reset release, then decoded_output = 16'h0020 with decode_valid pulsed 1 cycle -> next cycle out_valid = 1, out_index = 5, out_error = 0, fifo_level = 1, result_count = 1.
- Illegal words 16'h0000 and 16'h0104, one per cycle, with out_ready = 1 -> entries (index 0, err 1) then (index 2, err 1) drain in order; error_count = 2.
- out_ready = 0 and 9 consecutive valid pushes with FIFO_DEPTH = 8 -> fifo_level = 8, overflow_o = 1, result_count = 8; the 9th word is absent on drain.
- At full, push and pop in the same cycle -> fifo_level stays 8, overflow_o stays 0, the new entry appears last in drain order.
- Assert clear_i with result_count = 8 and overflow_o = 1 -> next cycle counters = 0, overflow_o = 0, FIFO contents still drain intact. Then assert pon_rst_i mid-drain -> out_valid = 0, fifo_level = 0.
- COLLECTOR_TIMEOUT_EN defined, TIMEOUT_CYCLES = 64, no decode_valid for 64 cycles -> timeout_o = 1 and stays set after a later decode_valid; clear_i drops it. With the macro undefined, timeout_o stays 0 throughout.
